data_pattern_gen: RTL and testbench
===================================

DATA_PATTERN_GEN -- requirements
Module: data_pattern_gen

Interface
REQ-001 Parameter DW, default 8: colour depth per channel, legal 4..12.
REQ-002 Parameter H_ACT, default 800: active pixels per line, legal 8..4095.
REQ-003 Parameter V_ACT, default 480: active lines per frame, legal 2..4095.
REQ-004 Parameter FRAME_HOLD, default 60: frames per pattern in auto-cycle, legal 1..65535.
REQ-005 Sys_Clock  in  1: single clock; all state updates on its rising edge.
REQ-006 Reset  in  1: reset, synchronous and active-high.
REQ-007 VSA  in  1: vertical sync active; a 0->1 transition marks frame start.
REQ-008 DE  in  1: data enable; active pixel when 1.
REQ-009 Pixel_Data_Cnt  in  16: active pixel index within line, 0..H_ACT-1.
REQ-010 Line_Data_Cnt  in  16: active line index within frame, 0..V_ACT-1.
REQ-011 Mode_Sel  in  3: requested pattern when Auto_En=0.
REQ-012 Auto_En  in  1: 1 = auto-cycle modes 0..5.
REQ-013 Solid_RGB  in  3*DW: solid colour {R,G,B}, R in MSBs.
REQ-014 R, G, B  out  DW each: registered pixel colour.
REQ-015 DE_Out  out  1: DE delayed to align with R/G/B.
REQ-016 Cur_Mode  out  3: pattern currently in effect.

Function
REQ-017 Frame-start pulse = VSA & ~VSA_d, where VSA_d is VSA registered one cycle.
REQ-018 Cur_Mode, and the Solid_RGB value used by mode 0, change only on a cycle with a frame-start pulse; they hold for the whole frame.
REQ-019 Manual (Auto_En=0) at frame start: Cur_Mode <= Mode_Sel; hold counter <= 0.
REQ-020 Auto (Auto_En=1) at frame start, if hold counter = FRAME_HOLD-1: hold counter <= 0 and Cur_Mode advances 0->1->..->5->0. A Cur_Mode of 6 or 7 advances to 0.
REQ-021 Auto at frame start, hold counter < FRAME_HOLD-1: hold counter increments and Cur_Mode is unchanged.
REQ-022 The hold counter is 16 bits wide.
REQ-023 Frame counter, DW bits, increments at every frame start regardless of mode, and wraps from 2^DW-1 to 0.
REQ-024 Mode 0, solid: pixel colour = latched Solid_RGB.
REQ-025 Mode 1, 8 vertical bars, with BW = H_ACT/8 (integer division):
  - bar index = Pixel_Data_Cnt/BW, saturated at 7;
  - bar order: white, yellow, cyan, green, magenta, red, blue, black;
  - channel full scale = 2^DW-1.
REQ-026 Mode 2, horizontal ramp: R=G=B=Pixel_Data_Cnt[DW-1:0], wrapping every 2^DW pixels.
REQ-027 Mode 3, checkerboard: white if Pixel_Data_Cnt[5]^Line_Data_Cnt[5]=1, else black.
REQ-028 Mode 4, border:
  - white if Pixel_Data_Cnt is 0 or H_ACT-1, or Line_Data_Cnt is 0 or V_ACT-1;
  - black otherwise.
REQ-029 Mode 5, flicker: R=G=B=frame counter.
REQ-030 Modes 6 and 7: black.
REQ-031 Latency is 1 cycle: R/G/B/DE_Out at edge n+1 reflect DE, Pixel_Data_Cnt and Line_Data_Cnt sampled at edge n.
REQ-032 When sampled DE=0, R=G=B=0 on the next cycle.
REQ-033 Counter values outside the active range produce no X or hold; mode 1 saturates and the other modes evaluate the formulas as written.
REQ-034 A frame start in the same cycle as DE=1 uses the already-updated Cur_Mode for that pixel.

Reset
REQ-035 While Reset=1, the following are held at 0: R, G, B, DE_Out, Cur_Mode, hold counter, frame counter, latched solid colour.
REQ-036 VSA_d resets to 1, so a VSA already high at reset release creates no frame-start pulse.
REQ-037 Reset asserted mid-frame takes effect on the next edge. Mode is then 0 with solid colour 0, giving black output until the first frame start after release.

Verification
REQ-038 DW=8, manual Mode_Sel=1, H_ACT=800, line sweep with DE=1:
  - pixel 0 -> FF,FF,FF;
  - pixel 100 -> FF,FF,00;
  - pixel 799 -> 00,00,00;
  - each output one cycle after its input.
REQ-039 Mode_Sel changed 0->3 mid-frame: Cur_Mode stays 0 until the next VSA rise. Then pixel 32 / line 0 -> FF,FF,FF and pixel 32 / line 32 -> 00,00,00.
REQ-040 Auto_En=1, FRAME_HOLD=2, 14 frame starts: Cur_Mode sequence 0,0,1,1,2,2,3,3,4,4,5,5,0,0 (value after each frame start).
REQ-041 Mode 5, 260 frames with DW=8: output gray value equals frame count mod 256, i.e. 03 after frame 259.
REQ-042 Cases with DE=0:
  - DE=0 with mode 0 and Solid_RGB=0xFF8000 -> R=G=B=0 and DE_Out=0 one cycle later;
  - Reset pulsed during an active line -> all outputs 0 on the next edge;
  - Reset released with VSA=1 -> Cur_Mode unchanged.
REQ-043 Mode 4, V_ACT=480: line 479, pixel 400 -> white; line 200, pixel 400 -> black; line 200, pixel 799 -> white.

Source files
------------

// File: rtl/data_pattern_gen_if.sv
// Pixel timing inputs, pattern controls and registered colour outputs
// of the test-pattern generator, bundled for a single port.
interface data_pattern_gen_if #(
    parameter int DW = 8
);
    logic          VSA;
    logic          DE;
    logic [15:0]   Pixel_Data_Cnt;
    logic [15:0]   Line_Data_Cnt;
    logic [2:0]    Mode_Sel;
    logic          Auto_En;
    logic [3*DW-1:0] Solid_RGB;
    logic [DW-1:0] R;
    logic [DW-1:0] G;
    logic [DW-1:0] B;
    logic          DE_Out;
    logic [2:0]    Cur_Mode;

    modport master (
        output VSA, DE, Pixel_Data_Cnt, Line_Data_Cnt,
        output Mode_Sel, Auto_En, Solid_RGB,
        input  R, G, B, DE_Out, Cur_Mode
    );

    modport slave (
        input  VSA, DE, Pixel_Data_Cnt, Line_Data_Cnt,
        input  Mode_Sel, Auto_En, Solid_RGB,
        output R, G, B, DE_Out, Cur_Mode
    );
endinterface

// File: rtl/data_pattern_gen.sv
// Video test-pattern generator: solid, colour bars, ramp, checker,
// border and flicker, selected per frame manually or by auto-cycle.
module data_pattern_gen #(
    parameter int DW         = 8,
    parameter int H_ACT      = 800,
    parameter int V_ACT      = 480,
    parameter int FRAME_HOLD = 60
) (
    input  logic Sys_Clock,
    input  logic Reset,
    data_pattern_gen_if.slave bus
);
    localparam int          BW       = H_ACT / 8;
    localparam logic [15:0] BW_W     = 16'(BW);
    localparam logic [15:0] HOLD_MAX = 16'(FRAME_HOLD - 1);
    localparam logic [15:0] H_LAST   = 16'(H_ACT - 1);
    localparam logic [15:0] V_LAST   = 16'(V_ACT - 1);
    localparam logic [DW-1:0] FULL   = {DW{1'b1}};

    logic            vsa_d;
    logic [2:0]      cur_mode;
    logic [15:0]     hold_cnt;
    logic [DW-1:0]   frame_cnt;
    logic [3*DW-1:0] solid_q;

    logic            frame_start;
    logic [2:0]      mode_nxt;
    logic [15:0]     hold_nxt;
    logic [DW-1:0]   frame_nxt;
    logic [3*DW-1:0] solid_nxt;

    logic [15:0]     bar_q;
    logic [2:0]      bar_idx;
    logic [2:0]      bar_mask;
    logic [3*DW-1:0] pix_rgb;

    assign frame_start = bus.VSA & ~vsa_d;

    // Per-frame state as it will be after this edge; the pixel path
    // uses it too so a pixel coinciding with frame start sees the new mode.
    always_comb begin
        mode_nxt  = cur_mode;
        hold_nxt  = hold_cnt;
        frame_nxt = frame_cnt;
        solid_nxt = solid_q;
        if (frame_start) begin
            frame_nxt = frame_cnt + 1'b1;
            solid_nxt = bus.Solid_RGB;
            if (!bus.Auto_En) begin
                mode_nxt = bus.Mode_Sel;
                hold_nxt = '0;
            end else if (hold_cnt == HOLD_MAX) begin
                hold_nxt = '0;
                mode_nxt = (cur_mode >= 3'd5) ? 3'd0 : cur_mode + 3'd1;
            end else begin
                hold_nxt = hold_cnt + 16'd1;
            end
        end
    end

    // Colour-bar index, saturating for pixels beyond the eighth bar.
    always_comb begin
        bar_q   = bus.Pixel_Data_Cnt / BW_W;
        bar_idx = (bar_q > 16'd7) ? 3'd7 : bar_q[2:0];
        unique case (bar_idx)
            3'd0:    bar_mask = 3'b111;
            3'd1:    bar_mask = 3'b110;
            3'd2:    bar_mask = 3'b011;
            3'd3:    bar_mask = 3'b010;
            3'd4:    bar_mask = 3'b101;
            3'd5:    bar_mask = 3'b100;
            3'd6:    bar_mask = 3'b001;
            default: bar_mask = 3'b000;
        endcase
    end

    // Pattern colour for the current pixel in the effective mode.
    always_comb begin
        pix_rgb = '0;
        unique case (mode_nxt)
            3'd0: pix_rgb = solid_nxt;
            3'd1: pix_rgb = {{DW{bar_mask[2]}},
                             {DW{bar_mask[1]}},
                             {DW{bar_mask[0]}}};
            3'd2: pix_rgb = {3{bus.Pixel_Data_Cnt[DW-1:0]}};
            3'd3: begin
                if (bus.Pixel_Data_Cnt[5] ^ bus.Line_Data_Cnt[5])
                    pix_rgb = {3{FULL}};
            end
            3'd4: begin
                if (bus.Pixel_Data_Cnt == 16'd0 ||
                    bus.Pixel_Data_Cnt == H_LAST ||
                    bus.Line_Data_Cnt == 16'd0 ||
                    bus.Line_Data_Cnt == V_LAST)
                    pix_rgb = {3{FULL}};
            end
            3'd5: pix_rgb = {3{frame_nxt}};
            default: pix_rgb = '0;
        endcase
    end

    // Frame-level state: sync edge detect, mode, hold and frame counters.
    always_ff @(posedge Sys_Clock) begin
        if (Reset) begin
            vsa_d     <= 1'b1;
            cur_mode  <= '0;
            hold_cnt  <= '0;
            frame_cnt <= '0;
            solid_q   <= '0;
        end else begin
            vsa_d     <= bus.VSA;
            cur_mode  <= mode_nxt;
            hold_cnt  <= hold_nxt;
            frame_cnt <= frame_nxt;
            solid_q   <= solid_nxt;
        end
    end

    // Registered pixel output, blanked outside data enable.
    always_ff @(posedge Sys_Clock) begin
        if (Reset) begin
            bus.R      <= '0;
            bus.G      <= '0;
            bus.B      <= '0;
            bus.DE_Out <= 1'b0;
        end else begin
            bus.DE_Out <= bus.DE;
            if (bus.DE) begin
                bus.R <= pix_rgb[3*DW-1:2*DW];
                bus.G <= pix_rgb[2*DW-1:DW];
                bus.B <= pix_rgb[DW-1:0];
            end else begin
                bus.R <= '0;
                bus.G <= '0;
                bus.B <= '0;
            end
        end
    end

    assign bus.Cur_Mode = cur_mode;

endmodule

// File: tb/tb_data_pattern_gen.sv
// Directed and random stimulus for data_pattern_gen, checked against
// a frame-level reference model of the pattern rules.
module tb_data_pattern_gen;
    localparam int DW = 8;
    localparam int H  = 800;
    localparam int V  = 480;
    localparam int FH = 2;

    localparam logic [23:0] BAR [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };
    localparam int SEQ [14] = '{0,0,1,1,2,2,3,3,4,4,5,5,0,0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int          m_mode, m_hold, m_frame;
    logic [23:0] m_solid;
    logic        m_vsa_d;
    logic [23:0] e_rgb;
    logic        e_de;

    data_pattern_gen_if #(.DW(DW)) bus ();

    data_pattern_gen #(
        .DW(DW), .H_ACT(H), .V_ACT(V), .FRAME_HOLD(FH)
    ) dut (
        .Sys_Clock(clk),
        .Reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref_pix(int mode, int p, int l,
                                            logic [23:0] solid, int frame);
        int idx;
        logic [7:0] g;
        case (mode)
            0: return solid;
            1: begin
                idx = p / (H / 8);
                if (idx > 7) idx = 7;
                return BAR[idx];
            end
            2: begin
                g = 8'(p % 256);
                return {g, g, g};
            end
            3: return (((p / 32) % 2) != ((l / 32) % 2)) ? 24'hFFFFFF : 24'h0;
            4: return (p == 0 || p == H - 1 || l == 0 || l == V - 1)
                      ? 24'hFFFFFF : 24'h0;
            5: begin
                g = 8'(frame % 256);
                return {g, g, g};
            end
            default: return 24'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic fs;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_hold = 0; m_frame = 0;
            m_solid = '0; m_vsa_d = 1'b1;
            e_rgb = '0; e_de = 1'b0;
        end else begin
            fs = bus.VSA && !m_vsa_d;
            m_vsa_d = bus.VSA;
            if (fs) begin
                m_frame = (m_frame + 1) % 256;
                m_solid = bus.Solid_RGB;
                if (!bus.Auto_En) begin
                    m_mode = int'(bus.Mode_Sel);
                    m_hold = 0;
                end else if (m_hold == FH - 1) begin
                    m_hold = 0;
                    m_mode = (m_mode < 5) ? m_mode + 1 : 0;
                end else begin
                    m_hold++;
                end
            end
            e_de = bus.DE;
            e_rgb = bus.DE ? ref_pix(m_mode, int'(bus.Pixel_Data_Cnt),
                                     int'(bus.Line_Data_Cnt), m_solid,
                                     m_frame) : 24'h0;
        end
        #1;
        chk("rgb", {8'h0, bus.R, bus.G, bus.B}, {8'h0, e_rgb});
        chk("de_out", 32'(bus.DE_Out), 32'(e_de));
        chk("cur_mode", 32'(bus.Cur_Mode), 32'(m_mode));
    endtask

    task automatic fstart();
        bus.DE = 1'b0;
        bus.VSA = 1'b0;
        tick();
        bus.VSA = 1'b1;
        tick();
    endtask

    task automatic pix(input int p, input int l);
        bus.DE = 1'b1;
        bus.Pixel_Data_Cnt = 16'(p);
        bus.Line_Data_Cnt = 16'(l);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.VSA = 1'b1;
        bus.DE = 1'b0;
        bus.Pixel_Data_Cnt = '0;
        bus.Line_Data_Cnt = '0;
        bus.Mode_Sel = 3'd0;
        bus.Auto_En = 1'b0;
        bus.Solid_RGB = '0;

        // Reset state, then release with VSA already high.
        tick();
        tick();
        chk("reset_rgb", {8'h0, bus.R, bus.G, bus.B}, 32'h0);
        chk("reset_mode", 32'(bus.Cur_Mode), 32'h0);
        rst = 1'b0;
        bus.Mode_Sel = 3'd3;
        repeat (3) tick();
        chk("rel_vsa_mode", 32'(bus.Cur_Mode), 32'h0);

        // Colour bars along a line.
        bus.Mode_Sel = 3'd1;
        fstart();
        pix(0, 10);
        chk("bar_p0", {8'h0, bus.R, bus.G, bus.B}, 32'hFFFFFF);
        pix(100, 10);
        chk("bar_p100", {8'h0, bus.R, bus.G, bus.B}, 32'hFFFF00);
        pix(799, 10);
        chk("bar_p799", {8'h0, bus.R, bus.G, bus.B}, 32'h000000);
        for (int p = 0; p < H; p += 37) pix(p, 11);

        // Mode change only takes effect at the next frame start.
        bus.Mode_Sel = 3'd0;
        fstart();
        bus.Mode_Sel = 3'd3;
        repeat (4) pix(5, 5);
        chk("hold_mode", 32'(bus.Cur_Mode), 32'h0);
        fstart();
        pix(32, 0);
        chk("chk_32_0", {8'h0, bus.R, bus.G, bus.B}, 32'hFFFFFF);
        pix(32, 32);
        chk("chk_32_32", {8'h0, bus.R, bus.G, bus.B}, 32'h000000);

        // Border.
        bus.Mode_Sel = 3'd4;
        fstart();
        pix(400, 479);
        chk("bord_479", {8'h0, bus.R, bus.G, bus.B}, 32'hFFFFFF);
        pix(400, 200);
        chk("bord_mid", {8'h0, bus.R, bus.G, bus.B}, 32'h000000);
        pix(799, 200);
        chk("bord_799", {8'h0, bus.R, bus.G, bus.B}, 32'hFFFFFF);

        // Solid colour and blanking.
        bus.Mode_Sel = 3'd0;
        bus.Solid_RGB = 24'hFF8000;
        fstart();
        pix(3, 3);
        chk("solid", {8'h0, bus.R, bus.G, bus.B}, 32'hFF8000);
        bus.DE = 1'b0;
        tick();
        chk("de0_rgb", {8'h0, bus.R, bus.G, bus.B}, 32'h0);
        chk("de0_deo", 32'(bus.DE_Out), 32'h0);

        // Reset during an active line.
        bus.DE = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_mid_rgb", {8'h0, bus.R, bus.G, bus.B}, 32'h0);
        chk("rst_mid_deo", 32'(bus.DE_Out), 32'h0);
        rst = 1'b0;
        repeat (2) pix(7, 7);

        // Flicker: gray tracks the frame count.
        do_reset();
        bus.Mode_Sel = 3'd5;
        repeat (259) fstart();
        pix(10, 10);
        chk("flicker_259", 32'(bus.R), 32'h03);
        fstart();
        pix(10, 10);

        // Auto-cycle, pre-conditioned so the sequence starts from mode 0.
        do_reset();
        bus.Mode_Sel = 3'd5;
        fstart();
        bus.Auto_En = 1'b1;
        fstart();
        for (int i = 0; i < 14; i++) begin
            fstart();
            chk("auto_seq", 32'(bus.Cur_Mode), 32'(SEQ[i]));
            pix(i * 50, i * 30);
        end

        // Random traffic, including out-of-range counters and
        // frame starts coinciding with active pixels.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) bus.VSA = ~bus.VSA;
            bus.DE = 1'($urandom_range(0, 3) != 0);
            bus.Pixel_Data_Cnt = 16'($urandom_range(0, 1000));
            bus.Line_Data_Cnt = 16'($urandom_range(0, 600));
            bus.Mode_Sel = 3'($urandom);
            if ($urandom_range(0, 49) == 0) bus.Auto_En = ~bus.Auto_En;
            bus.Solid_RGB = 24'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
